// File: rtl/port_rst_sequencer.sv
// Per-port soft-reset merge and sequencer. Each port request is synchronised, held low for a
// minimum time, released staggered by port index, and optionally drained before reset.
module port_rst_sequencer #(
    parameter int NUM_PORTS       = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int MIN_ASSERT_CYC  = 16,
    parameter int STAGGER_CYC     = 8,
    parameter int QUIESCE_EN      = 1,
    parameter int QUIESCE_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] port_rst_n_in,
    input  logic [NUM_PORTS-1:0] quiesce_ack,
    output logic [NUM_PORTS-1:0] quiesce_req,
    output logic [NUM_PORTS-1:0] port_rst_n_out,
    output logic [NUM_PORTS-1:0] port_in_reset,
    output logic [NUM_PORTS-1:0] quiesce_timeout_err
);

    localparam int STAG_MAX = (NUM_PORTS - 1) * STAGGER_CYC;
    localparam int MAX_AB   = (MIN_ASSERT_CYC > STAG_MAX) ? MIN_ASSERT_CYC : STAG_MAX;
    localparam int CNT_MAX  = (MAX_AB > QUIESCE_TIMEOUT) ? MAX_AB : QUIESCE_TIMEOUT;
    localparam int CW       = $clog2(CNT_MAX + 1);

    typedef logic [CW-1:0] cnt_t;
    typedef enum logic [1:0] {ST_ASSERT, ST_STAGGER, ST_RUN, ST_QUIESCE} state_t;

    localparam cnt_t CNT_SAT = '1;
    localparam cnt_t MIN_M1  = cnt_t'(MIN_ASSERT_CYC - 1);
    localparam cnt_t QTO_M1  = cnt_t'(QUIESCE_TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] sync_q  [NUM_PORTS];
    state_t                 state_q [NUM_PORTS];
    state_t                 state_d [NUM_PORTS];
    cnt_t                   cnt_q   [NUM_PORTS];
    cnt_t                   cnt_d   [NUM_PORTS];
    logic [NUM_PORTS-1:0]   req_s;
    logic [NUM_PORTS-1:0]   err_d;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            req_s[p] = sync_q[p][SYNC_STAGES-1];
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            // NOTE: every variable gets a default before the case so no path infers a latch.
            state_d[p] = state_q[p];
            cnt_d[p]   = (cnt_q[p] == CNT_SAT) ? cnt_q[p] : cnt_q[p] + cnt_t'(1);
            err_d[p]   = quiesce_timeout_err[p];

            case (state_q[p])
                ST_ASSERT: begin
                    if (req_s[p] && (cnt_q[p] >= MIN_M1)) begin
                        state_d[p] = ST_STAGGER;
                        cnt_d[p]   = '0;
                    end
                end
                ST_STAGGER: begin
                    if (!req_s[p]) begin
                        state_d[p] = ST_ASSERT;
                        cnt_d[p]   = '0;
                    end else if (cnt_q[p] >= cnt_t'(p * STAGGER_CYC)) begin
                        state_d[p] = ST_RUN;
                        cnt_d[p]   = '0;
                    end
                end
                ST_RUN: begin
                    if (!req_s[p]) begin
                        state_d[p] = (QUIESCE_EN != 0) ? ST_QUIESCE : ST_ASSERT;
                        cnt_d[p]   = '0;
                    end
                end
                default: begin
                    // Once draining starts the reset is committed; only ack or timeout exit.
                    if (quiesce_ack[p]) begin
                        state_d[p] = ST_ASSERT;
                        cnt_d[p]   = '0;
                    end else if (cnt_q[p] == QTO_M1) begin
                        state_d[p] = ST_ASSERT;
                        cnt_d[p]   = '0;
                        err_d[p]   = 1'b1;
                    end
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (rst) begin
                // NOTE: sequential state uses non-blocking assignments so all flops update together.
                sync_q[p]              <= '0;
                state_q[p]             <= ST_ASSERT;
                cnt_q[p]               <= '0;
                port_rst_n_out[p]      <= 1'b0;
                quiesce_req[p]         <= 1'b0;
                port_in_reset[p]       <= 1'b1;
                quiesce_timeout_err[p] <= 1'b0;
            end else begin
                sync_q[p][0] <= port_rst_n_in[p];
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[p][i] <= sync_q[p][i-1];
                end
                state_q[p]             <= state_d[p];
                cnt_q[p]               <= cnt_d[p];
                port_rst_n_out[p]      <= (state_d[p] == ST_RUN) || (state_d[p] == ST_QUIESCE);
                quiesce_req[p]         <= (state_d[p] == ST_QUIESCE);
                port_in_reset[p]       <= (state_d[p] != ST_RUN);
                quiesce_timeout_err[p] <= err_d[p];
            end
        end
    end

endmodule
